// File: rtl/riscky_pkg.sv
// riscky_pkg: shared state enum, opcodes and datapath select encodings for the multicycle core.
// The JAL state exists only when RISCKY_JAL_EN is defined.
package riscky_pkg;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ
`ifdef RISCKY_JAL_EN
      , JAL
`endif
   } state_t;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_READ = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;
   localparam logic [1:0] SRCA_PC = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1 = 2'b10;
   localparam logic [1:0] SRCB_RS2 = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;
   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;
endpackage

// File: rtl/imm_src_decoder.sv
// imm_src_decoder: combinational opcode to immediate-format select.
// J format is decoded only when RISCKY_JAL_EN is defined.
module imm_src_decoder
   import riscky_pkg::*;
(
   input  logic [6:0] op,
   output logic [1:0] imm_src
);
`ifdef RISCKY_JAL_EN
   assign imm_src = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
`else
   assign imm_src = op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : IMM_I;
`endif
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the shared-ALU RISC-V datapath with MEM_WAIT-cycle memories.
// Define RISCKY_JAL_EN to add the jal path.
module multicycle_controller
   import riscky_pkg::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc,
   output logic       illegal
);
   state_t state, state_n;
   logic [3:0] cnt;
   logic mem_st, done, pc_update, branch, ir_write, reg_write, mem_write, ill;

   assign mem_st = state inside {FETCH, MEMREAD, MEMWRITE};
   assign done = cnt == 4'(MEM_WAIT);

   // counter only runs inside memory states, so it is already 0 on entry to the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= mem_st && !done ? cnt + 4'd1 : '0;
      end
   end

   always_comb begin
      state_n = state;
      AdrSrc = 1'b0;
      ResultSrc = RES_ALUOUT;
      ALUSrcA = SRCA_PC;
      ALUSrcB = SRCB_RS2;
      ALUOp = ALU_ADD;
      pc_update = 1'b0;
      branch = 1'b0;
      ir_write = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      ill = 1'b0;
      case (state)
         FETCH: begin
            ALUSrcB = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            ir_write = done;
            pc_update = done;
            state_n = done ? DECODE : FETCH;
         end
         DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            case (op)
               OP_LW, OP_SW: state_n = MEMADR;
               OP_R:         state_n = EXECUTER;
               OP_I:         state_n = EXECUTEI;
               OP_BEQ:       state_n = BEQ;
`ifdef RISCKY_JAL_EN
               OP_JAL:       state_n = JAL;
`endif
               default: begin
                  ill = 1'b1;
                  state_n = FETCH;
               end
            endcase
         end
         MEMADR: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            state_n = op == OP_LW ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            state_n = done ? MEMWB : MEMREAD;
         end
         MEMWB: begin
            ResultSrc = RES_READ;
            reg_write = 1'b1;
            state_n = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_write = 1'b1;
            state_n = done ? FETCH : MEMWRITE;
         end
         EXECUTER: begin
            ALUSrcA = SRCA_RS1;
            ALUOp = ALU_FUNCT;
            state_n = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_IMM;
            ALUOp = ALU_FUNCT;
            state_n = ALUWB;
         end
         ALUWB: begin
            reg_write = 1'b1;
            state_n = FETCH;
         end
         BEQ: begin
            ALUSrcA = SRCA_RS1;
            ALUOp = ALU_SUB;
            branch = 1'b1;
            state_n = FETCH;
         end
`ifdef RISCKY_JAL_EN
         JAL: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_FOUR;
            pc_update = 1'b1;
            state_n = ALUWB;
         end
`endif
         default: state_n = FETCH;
      endcase
   end

   // strobes are gated by rst so nothing fires while reset is held
   assign PCWrite = !rst && (pc_update || (branch && zero));
   assign IRWrite = !rst && ir_write;
   assign MemWrite = !rst && mem_write;
   assign RegWrite = !rst && reg_write;
   assign illegal = !rst && ill;

   imm_src_decoder u_imm (
      .op(op),
      .imm_src(ImmSrc)
   );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams on MEM_WAIT = 0 and 2 instances,
// compared cycle by cycle against a phase-table model of the instruction sequencing.
module tb_multicycle_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] op [2];
   logic zero [2];
   logic [15:0] obs [2];
   logic [15:0] exp_q [$];
   logic [1:0] cur_imm;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : u
      logic pcw, adr, mw, irw, rw, ill;
      logic [1:0] rs, sa, sb, aop, imm;
      multicycle_controller #(.MEM_WAIT(g * 2)) dut (
         .clk(clk), .rst(rst), .op(op[g]), .zero(zero[g]),
         .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw), .IRWrite(irw), .RegWrite(rw),
         .ResultSrc(rs), .ALUSrcA(sa), .ALUSrcB(sb), .ALUOp(aop), .ImmSrc(imm), .illegal(ill)
      );
      assign obs[g] = {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm, ill};
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   function automatic bit jal_en();
`ifdef RISCKY_JAL_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit legal(input logic [6:0] o);
      return o == 7'h03 || o == 7'h23 || o == 7'h33 || o == 7'h13 || o == 7'h63 || (o == 7'h6f && jal_en());
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      return o == 7'h23 ? 2'b01 : o == 7'h63 ? 2'b10 : (o == 7'h6f && jal_en()) ? 2'b11 : 2'b00;
   endfunction

   function automatic logic [15:0] v(input bit pcw, adr, mw, irw, rw, input logic [1:0] rs, sa, sb, aop, input bit ill);
      return {pcw, adr, mw, irw, rw, rs, sa, sb, aop, cur_imm, ill};
   endfunction

   // expected output vector for every cycle of one instruction, phase by phase
   task automatic build(input logic [6:0] o, input bit z, input int w);
      exp_q.delete();
      cur_imm = imm_of(o);
      for (int c = 0; c <= w; c++) exp_q.push_back(v(c == w, 0, 0, c == w, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
      exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, !legal(o)));
      if (o == 7'h03 || o == 7'h23) exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0));
      if (o == 7'h03) begin
         for (int c = 0; c <= w; c++) exp_q.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
         exp_q.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0));
      end
      if (o == 7'h23)
         for (int c = 0; c <= w; c++) exp_q.push_back(v(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      if (o == 7'h33) exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0));
      if (o == 7'h13) exp_q.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0));
      if (o == 7'h6f && jal_en()) exp_q.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0));
      if (o == 7'h33 || o == 7'h13 || (o == 7'h6f && jal_en()))
         exp_q.push_back(v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0));
      if (o == 7'h63) exp_q.push_back(v(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0));
   endtask

   // entered and left at posedge + 1 with the DUT in its first FETCH cycle
   task automatic run(input int k, input logic [6:0] o, input bit z, input string name);
      op[k] = o;
      zero[k] = z;
      build(o, z, k * 2);
      for (int i = 0; i < exp_q.size(); i++) begin
         #2 check($sformatf("%s_k%0d_c%0d", name, k, i), obs[k], exp_q[i]);
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic rst_mid(input int k);
      int w = k * 2;
      op[k] = 7'h03;
      zero[k] = 1'b0;
      build(7'h03, 1'b0, w);
      for (int i = 0; i < w + 3; i++) begin
         #2 check($sformatf("pre_rst_k%0d_c%0d", k, i), obs[k], exp_q[i]);
         @(posedge clk);
         #1;
      end
      #1 check($sformatf("memread_k%0d", k), obs[k], exp_q[w + 3]);
      rst = 1'b1;
      #1 check($sformatf("rst_async_k%0d", k), obs[k], v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
      @(posedge clk);
      #1 check($sformatf("rst_hold_k%0d", k), obs[k], v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
      rst = 1'b0;
      run(k, 7'h23, 1'b0, "post_rst_sw");
   endtask

   initial begin
      logic [6:0] list [6];
      logic [6:0] o;
      list = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f};
      for (int k = 0; k < 2; k++) begin
         op[k] = 7'h03;
         zero[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      #2 cur_imm = 2'b00;
      for (int k = 0; k < 2; k++)
         check($sformatf("reset_k%0d", k), obs[k], v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0));
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         pulse_rst();
         run(k, 7'h03, 1'b0, "lw");
         run(k, 7'h63, 1'b1, "beq_taken");
         run(k, 7'h63, 1'b0, "beq_not");
         run(k, 7'h23, 1'b1, "sw");
         run(k, 7'h7f, 1'b0, "illegal");
         run(k, 7'h6f, 1'b1, "jal");
         run(k, 7'h33, 1'b1, "rtype");
         run(k, 7'h13, 1'b0, "itype");
         for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 6) == 6) begin
               do o = 7'($urandom); while (legal(o));
            end else o = list[$urandom_range(0, 5)];
            run(k, o, 1'($urandom), $sformatf("rand%0d_op%h", n, o));
         end
         rst_mid(k);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
